// File: rtl/joy_db15_pkg.sv
// Shared definitions for the DB15 serial joystick link (responder and reader side).
package joy_db15_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

   localparam int WORD_BITS_DEF = 16;
   localparam int FRAME_BITS    = 2 * WORD_BITS_DEF;

   // Button bit positions in a player word, map LS FEDCBAUDLR (bit 0 = R)
   localparam int BTN_RIGHT = 0;
   localparam int BTN_LEFT  = 1;
   localparam int BTN_DOWN  = 2;
   localparam int BTN_UP    = 3;
   localparam int BTN_A     = 4;
   localparam int BTN_B     = 5;
   localparam int BTN_C     = 6;
   localparam int BTN_D     = 7;
   localparam int BTN_E     = 8;
   localparam int BTN_F     = 9;
   localparam int BTN_START = 10;
   localparam int BTN_L     = 11;

   function automatic int frame_bits(input int word_bits);
      return 2 * word_bits;
   endfunction

endpackage

// File: rtl/joy_db15_resp_if.sv
// DB15 serial link pins: host drives shift clock and load, responder drives data.
interface joy_db15_resp_if;
   logic joy_clk;
   logic joy_load;
   logic joy_data;

   modport master (output joy_clk, output joy_load, input joy_data);
   modport slave  (input joy_clk, input joy_load, output joy_data);
endinterface

// File: rtl/sync_edge.sv
// Multi-stage synchroniser for an async pin plus registered rise/fall detect.
module sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic async_sig,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync;
   logic              prev;

   // Reset to 1 so a pin idling high does not produce an edge after reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync <= '1;
         prev <= 1'b1;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         sync <= {sync[STAGES-2:0], async_sig};
         prev <= sync[STAGES-1];
         rise <= sync[STAGES-1] & ~prev;
         fall <= ~sync[STAGES-1] & prev;
      end
   end

endmodule

// File: rtl/joy_db15_resp.sv
// DB15 joystick responder: emulates the adapter's '165 chain, two player words
// snapshotted on joy_load low and shifted out MSB first on joy_clk rising edges.
//
// state | meaning
// IDLE  | no frame active, joy_data held at 1
// LOAD  | joy_load low, sr transparently tracks inverted button words
// SHIFT | frame active, one bit per host clock edge, watchdog running
module joy_db15_resp
   import joy_db15_pkg::*;
#(
   parameter int WORD_BITS   = 16,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 4096
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WORD_BITS-1:0] joystick1,
   input  logic [WORD_BITS-1:0] joystick2,
   joy_db15_resp_if.slave       link,
   output logic                 busy,
   output logic                 frame_done,
   output logic                 frame_error
);

   localparam int FRAME = frame_bits(WORD_BITS);
   localparam int CNT_W = $clog2(FRAME);
   localparam int WD_W  = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME - 1);
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

   state_t           state, state_n;
   logic [FRAME-1:0] sr, sr_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [WD_W-1:0]  wd, wd_n;

   logic clk_rise, clk_fall_unused;
   logic load_rise, load_fall;

   sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clk (
      .clk       (clk),
      .reset     (reset),
      .async_sig (link.joy_clk),
      .rise      (clk_rise),
      .fall      (clk_fall_unused)
   );

   sync_edge #(.STAGES(SYNC_STAGES)) u_sync_load (
      .clk       (clk),
      .reset     (reset),
      .async_sig (link.joy_load),
      .rise      (load_rise),
      .fall      (load_fall)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         sr    <= '1;
         cnt   <= '0;
         wd    <= '0;
      end else begin
         state <= state_n;
         sr    <= sr_n;
         cnt   <= cnt_n;
         wd    <= wd_n;
      end
   end

   always_comb begin
      state_n     = state;
      sr_n        = sr;
      cnt_n       = cnt;
      wd_n        = wd;
      frame_done  = 1'b0;
      frame_error = 1'b0;
      unique case (state)
         IDLE: begin
            if (load_fall) state_n = LOAD;
         end
         LOAD: begin
            if (load_rise) begin
               state_n = SHIFT;
               cnt_n   = '0;
               wd_n    = '0;
            end else begin
               sr_n = {~joystick1, ~joystick2};
            end
         end
         SHIFT: begin
            // A reload beats a coincident shift edge; that edge is dropped.
            if (load_fall) begin
               frame_error = 1'b1;
               state_n     = LOAD;
            end else if (clk_rise) begin
               sr_n = {sr[FRAME-2:0], 1'b1};
               wd_n = '0;
               if (cnt == CNT_LAST) begin
                  frame_done = 1'b1;
                  state_n    = IDLE;
               end else begin
                  cnt_n = cnt + CNT_W'(1);
               end
            end else if (wd == WD_LAST) begin
               frame_error = 1'b1;
               state_n     = IDLE;
            end else begin
               wd_n = wd + WD_W'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign link.joy_data = (state == IDLE) ? 1'b1 : sr[FRAME-1];
   assign busy          = (state != IDLE);

endmodule
